riscv_dmem_resp: RTL

RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/riscv_mtimer.sv | 80 ++++++++
 rtl/riscv_dmem_resp.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions: access-size encodings, timer MMIO offsets and CTRL bits.
// Used by both the data-memory responder and the CPU load/store path.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MemSizeByte = 2'b00,
    MemSizeHalf = 2'b01,
    MemSizeWord = 2'b10,
    MemSizeRsvd = 2'b11
  } mem_size_e;

  // Byte offsets within the 32-byte timer window
  localparam logic [4:0] MmioMtimeLo    = 5'h00;
  localparam logic [4:0] MmioMtimeHi    = 5'h04;
  localparam logic [4:0] MmioMtimecmpLo = 5'h08;
  localparam logic [4:0] MmioMtimecmpHi = 5'h0C;
  localparam logic [4:0] MmioCtrl       = 5'h10;

  localparam int unsigned CtrlEnBit = 0;

endpackage

// File: rtl/riscv_mtimer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp, CTRL.EN, registered compare interrupt.
// Only instantiated when RISCV_DMEM_TIMER_EN is defined.
module riscv_mtimer
  import riscv_mem_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic [PW-1:0] r_presc;
  logic          r_en;
  logic          r_irq;

  logic w_tick;
  logic w_wr_mtime_lo;
  logic w_wr_mtime_hi;
  logic w_wr_cmp_lo;
  logic w_wr_cmp_hi;
  logic w_wr_ctrl;

  assign w_tick        = r_en && (r_presc == PRESC_MAX);
  assign w_wr_mtime_lo = i_we && (i_off == MmioMtimeLo);
  assign w_wr_mtime_hi = i_we && (i_off == MmioMtimeHi);
  assign w_wr_cmp_lo   = i_we && (i_off == MmioMtimecmpLo);
  assign w_wr_cmp_hi   = i_we && (i_off == MmioMtimecmpHi);
  assign w_wr_ctrl     = i_we && (i_off == MmioCtrl);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_presc    <= '0;
      r_en       <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (r_en) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      // A store to either half wins over the increment; the other half holds
      if (w_wr_mtime_lo) begin
        r_mtime[31:0] <= i_wdata;
      end else if (w_wr_mtime_hi) begin
        r_mtime[63:32] <= i_wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= i_wdata;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= i_wdata;
      if (w_wr_ctrl)   r_en              <= i_wdata[CtrlEnBit];
      r_irq <= r_en && (r_mtime >= r_mtimecmp);
    end
  end

  always_comb begin
    o_rdata = '0;
    case ({i_off[4:2], 2'b00})
      MmioMtimeLo:    o_rdata = r_mtime[31:0];
      MmioMtimeHi:    o_rdata = r_mtime[63:32];
      MmioMtimecmpLo: o_rdata = r_mtimecmp[31:0];
      MmioMtimecmpHi: o_rdata = r_mtimecmp[63:32];
      MmioCtrl:       o_rdata[CtrlEnBit] = r_en;
      default:        o_rdata = '0;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/riscv_dmem_resp.sv
// Zero-wait-state data RAM with byte/half/word stores and an optional timer MMIO window.
// Define RISCV_DMEM_TIMER_EN to build the machine timer into the window.
module riscv_dmem_resp
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [1:0]  MemSize,
  output logic [31:0] ReadData,
  output logic        TimerIrq,
  output logic        MisalignErr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic        r_misalign;

  logic [31:0]   w_off;
  logic          w_mmio;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_misalign;
  logic          w_ram_we;
  logic [31:0]   w_timer_rdata;

  assign w_off  = Mem_WrAddr - MMIO_BASE;
  assign w_mmio = (Mem_WrAddr >= MMIO_BASE) && (w_off < 32'd32);
  assign w_idx  = Mem_WrAddr[AW+1:2];

  // Replicate store data across lanes so the byte enables alone pick the target
  always_comb begin
    w_be       = 4'b0000;
    w_wdata    = Mem_WrData;
    w_misalign = 1'b0;
    case (mem_size_e'(MemSize))
      MemSizeByte: begin
        w_be    = 4'b0001 << Mem_WrAddr[1:0];
        w_wdata = {4{Mem_WrData[7:0]}};
      end
      MemSizeHalf: begin
        w_be       = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{Mem_WrData[15:0]}};
        w_misalign = Mem_WrAddr[0];
      end
      default: begin
        w_be       = 4'b1111;
        w_misalign = |Mem_WrAddr[1:0];
      end
    endcase
  end

  assign w_ram_we = MemWrite && !w_mmio && !w_misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (MemWrite && w_misalign) begin
      r_misalign <= 1'b1;
    end
  end

  // RAM is not reset, but a store coinciding with reset is discarded
  always_ff @(posedge clk) begin
    if (w_ram_we && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

`ifdef RISCV_DMEM_TIMER_EN
  logic w_timer_we;

  assign w_timer_we = MemWrite && w_mmio && MemSize[1] && !w_misalign;

  riscv_mtimer #(
    .PRESCALE (PRESCALE)
  ) u_mtimer (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_timer_we),
    .i_off   (w_off[4:0]),
    .i_wdata (Mem_WrData),
    .o_rdata (w_timer_rdata),
    .o_irq   (TimerIrq)
  );
`else
  assign w_timer_rdata = '0;
  assign TimerIrq      = 1'b0;
`endif

  assign ReadData    = w_mmio ? w_timer_rdata : r_mem[w_idx];
  assign MisalignErr = r_misalign;

endmodule
